button_encoder: RTL and testbench



---
 rtl/button_encoder_if.sv | 49 ++++
 rtl/button_encoder.sv | 183 ++++++++++++++++++
 tb/tb_button_encoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_encoder_if.sv
// Player-input port bundle between the color buttons / game controller and button_encoder.
// ECHO / ECHO_VALID exist only when BUTTON_ECHO_EN is defined.
interface button_encoder_if;
    logic [3:0] BTN;
    logic       ENABLE;
    logic [1:0] IN;
    logic       IN_VALID;
    logic       ERR;
`ifdef BUTTON_ECHO_EN
    logic [1:0] ECHO;
    logic       ECHO_VALID;

    modport master (
        output BTN,
        output ENABLE,
        input  IN,
        input  IN_VALID,
        input  ERR,
        input  ECHO,
        input  ECHO_VALID
    );

    modport slave (
        input  BTN,
        input  ENABLE,
        output IN,
        output IN_VALID,
        output ERR,
        output ECHO,
        output ECHO_VALID
    );
`else
    modport master (
        output BTN,
        output ENABLE,
        input  IN,
        input  IN_VALID,
        input  ERR
    );

    modport slave (
        input  BTN,
        input  ENABLE,
        output IN,
        output IN_VALID,
        output ERR
    );
`endif
endinterface

// File: rtl/button_encoder.sv
// Four bouncy color buttons -> synchronized, debounced 2-bit code with IN_VALID / ERR strobes.
// Optional BUTTON_ECHO_EN adds ECHO / ECHO_VALID, showing the held color on the display.
module button_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic           CLK,
    input  logic           RST,
    button_encoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StHeld,
        StDebRelease
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       in_q, in_d;
    logic             in_valid_q, in_valid_d;
    logic             err_q, err_d;
`ifdef BUTTON_ECHO_EN
    logic [1:0]       echo_q, echo_d;
    logic             echo_valid_q, echo_valid_d;
`endif

    logic [3:0] s;
    logic       s_zero;
    logic       s_onehot;
    logic       s_multi;
    logic [1:0] s_code;
    logic [3:0] latched_onehot;

    // Two-flop synchronizer per button; only the second stage feeds the FSM.
    assign sync1_d = bus.BTN;
    assign sync2_d = sync1_q;

    assign s              = sync2_q;
    assign s_zero         = (s == 4'b0000);
    assign s_onehot       = !s_zero && ((s & (s - 4'd1)) == 4'b0000);
    assign s_multi        = !s_zero && !s_onehot;
    assign latched_onehot = 4'b0001 << code_q;

    always_comb begin
        s_code = 2'd0;
        unique case (s)
            4'b0001: s_code = 2'd0;
            4'b0010: s_code = 2'd1;
            4'b0100: s_code = 2'd2;
            4'b1000: s_code = 2'd3;
            default: s_code = 2'd0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        in_d         = in_q;
        in_valid_d   = 1'b0;
        err_d        = 1'b0;
`ifdef BUTTON_ECHO_EN
        echo_d       = echo_q;
        echo_valid_d = echo_valid_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (s_onehot) begin
                    code_d  = s_code;
                    cnt_d   = '0;
                    state_d = StDebPress;
                end else if (s_multi) begin
                    err_d   = 1'b1;
                    state_d = StHeld;
`ifdef BUTTON_ECHO_EN
                    echo_valid_d = 1'b0;
`endif
                end
            end

            StDebPress: begin
                if (s == latched_onehot) begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = StHeld;
                        // ENABLE matters only here; a disabled qualification is consumed.
                        if (bus.ENABLE) begin
                            in_d       = code_q;
                            in_valid_d = 1'b1;
                        end
`ifdef BUTTON_ECHO_EN
                        echo_d       = code_q;
                        echo_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (s_multi) begin
                    err_d   = 1'b1;
                    state_d = StHeld;
`ifdef BUTTON_ECHO_EN
                    echo_valid_d = 1'b0;
`endif
                end else begin
                    state_d = StIdle;
`ifdef BUTTON_ECHO_EN
                    echo_valid_d = 1'b0;
`endif
                end
            end

            StHeld: begin
                if (s_zero) begin
                    cnt_d   = '0;
                    state_d = StDebRelease;
                end
            end

            StDebRelease: begin
                if (!s_zero) begin
                    state_d = StHeld;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StIdle;
`ifdef BUTTON_ECHO_EN
                    echo_valid_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            sync1_q      <= '0;
            sync2_q      <= '0;
            cnt_q        <= '0;
            code_q       <= '0;
            in_q         <= '0;
            in_valid_q   <= 1'b0;
            err_q        <= 1'b0;
`ifdef BUTTON_ECHO_EN
            echo_q       <= '0;
            echo_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            in_q         <= in_d;
            in_valid_q   <= in_valid_d;
            err_q        <= err_d;
`ifdef BUTTON_ECHO_EN
            echo_q       <= echo_d;
            echo_valid_q <= echo_valid_d;
`endif
        end
    end

    assign bus.IN       = in_q;
    assign bus.IN_VALID = in_valid_q;
    assign bus.ERR      = err_q;
`ifdef BUTTON_ECHO_EN
    assign bus.ECHO       = echo_q;
    assign bus.ECHO_VALID = echo_valid_q;
`endif

endmodule

// File: tb/tb_button_encoder.sv
// Scoreboard bench for button_encoder with DEBOUNCE_CYCLES=4: expected strobes are queued
// with their due cycle at stimulus time and matched as IN_VALID / ERR appear.
module tb_button_encoder;

    localparam int unsigned Deb = 4;
    localparam int PressLat = Deb + 3;
    localparam int ErrLat   = 3;

    typedef struct {
        int code;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   in_model;
    exp_t valid_q[$];
    int   err_q[$];

    button_encoder_if bus ();

    button_encoder #(
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        bus.BTN = v;
    endtask

    task automatic expect_valid(input int code);
        exp_t e;
        e.code = code;
        e.cyc  = cyc + PressLat;
        valid_q.push_back(e);
    endtask

    task automatic expect_err();
        err_q.push_back(cyc + ErrLat);
    endtask

    // Monitor: every strobe must match the head of its queue, and IN must hold between strobes.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.IN_VALID === 1'b1 && bus.ERR === 1'b1) begin
                check_eq("valid_err_overlap", 1, 0);
            end
            if (bus.IN_VALID === 1'b1) begin
                if (valid_q.size() == 0) begin
                    check_eq("spurious_valid", int'(bus.IN), -1);
                end else begin
                    exp_t e;
                    e = valid_q.pop_front();
                    check_eq("valid_code", int'(bus.IN), e.code);
                    check_eq("valid_cycle", cyc, e.cyc);
                    in_model = e.code;
                end
            end else begin
                check_eq("in_hold", int'(bus.IN), in_model);
            end
            if (bus.ERR === 1'b1) begin
                if (err_q.size() == 0) begin
                    check_eq("spurious_err", cyc, -1);
                end else begin
                    check_eq("err_cycle", cyc, err_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in"}, int'(bus.IN), 0);
        check_eq({tag, "_valid"}, int'(bus.IN_VALID), 0);
        check_eq({tag, "_err"}, int'(bus.ERR), 0);
`ifdef BUTTON_ECHO_EN
        check_eq({tag, "_echo"}, int'(bus.ECHO), 0);
        check_eq({tag, "_echo_valid"}, int'(bus.ECHO_VALID), 0);
`endif
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_valid_pending"}, valid_q.size(), 0);
        check_eq({tag, "_err_pending"}, err_q.size(), 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        in_model   = 0;
        rst        = 1'b1;
        bus.BTN    = 4'b0000;
        bus.ENABLE = 1'b1;

        wait_cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Clean press of color 2, long hold, release, idle.
        drive(4'b0100);
        expect_valid(2);
        wait_cyc(20);
        drive(4'b0000);
        wait_cyc(30);
        check_drained("t1");

        // Bouncy press of color 0, then stable.
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? 4'b0001 : 4'b0000);
            wait_cyc(2);
        end
        drive(4'b0001);
        expect_valid(0);
        wait_cyc(12);
        drive(4'b0000);
        wait_cyc(12);
        check_drained("t2");

        // Two buttons at once is rejected; a later single press is accepted.
        drive(4'b0011);
        expect_err();
        wait_cyc(10);
        drive(4'b0000);
        wait_cyc(8);
        drive(4'b1000);
        expect_valid(3);
        wait_cyc(12);
        drive(4'b0000);
        wait_cyc(10);
        check_drained("t3");

        // Extra button mid-hold and a bouncy release give nothing extra.
        drive(4'b0010);
        expect_valid(1);
        wait_cyc(10);
        drive(4'b1010);
        wait_cyc(5);
        drive(4'b0010);
        wait_cyc(5);
        drive(4'b0000);
        wait_cyc(1);
        drive(4'b0010);
        wait_cyc(1);
        drive(4'b0000);
        wait_cyc(1);
        drive(4'b0010);
        wait_cyc(1);
        drive(4'b0000);
        wait_cyc(12);
        check_drained("t4");

        // Reset in the middle of press debounce with the button held.
        drive(4'b0100);
        wait_cyc(4);
        rst      = 1'b1;
        in_model = 0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            check_reset_outputs("midreset");
        end
        rst = 1'b0;
        expect_valid(2);
        wait_cyc(10);
`ifdef BUTTON_ECHO_EN
        check_eq("echo_held_valid", int'(bus.ECHO_VALID), 1);
        check_eq("echo_held_code", int'(bus.ECHO), 2);
`endif
        drive(4'b0000);
        wait_cyc(12);
`ifdef BUTTON_ECHO_EN
        check_eq("echo_released_valid", int'(bus.ECHO_VALID), 0);
`endif
        check_drained("t6");

        // Qualification with ENABLE low is swallowed; raising ENABLE while held gives no strobe.
        bus.ENABLE = 1'b0;
        drive(4'b0001);
        wait_cyc(10);
`ifdef BUTTON_ECHO_EN
        check_eq("echo_disabled_valid", int'(bus.ECHO_VALID), 1);
        check_eq("echo_disabled_code", int'(bus.ECHO), 0);
`endif
        bus.ENABLE = 1'b1;
        wait_cyc(10);
        drive(4'b0000);
        wait_cyc(10);
        check_drained("t5_disabled");
        drive(4'b0001);
        expect_valid(0);
        wait_cyc(12);
        drive(4'b0000);
        wait_cyc(12);
        check_drained("t5");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
